// File: rtl/bicubic_dot_pipe.sv
// bicubic_dot_pipe
//   Sign-magnitude dot product of TAPS weight/pixel pairs for bicubic
//   interpolation. Three register stages, globally stalled by a valid/ready
//   handshake on the output.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_valid     : input vector valid
//   in_ready     : input accepted this cycle when in_valid is also high
//   weight_vec   : TAPS sign-magnitude weights, tap i at [i*(WW+1) +: WW+1]
//   pixel_vec    : TAPS sign-magnitude pixels,  tap i at [i*(PW+1) +: PW+1]
//   out_valid    : result valid
//   out_ready    : downstream accepts result
//   out_mag      : result magnitude (saturated or wrapped to OW bits)
//   out_sign     : result sign, 1 = negative, never set for a zero result
//   out_ovf      : this result did not fit in OW bits
//   ovf_sticky   : set by any accepted overflowing result
//   clr_ovf      : synchronous clear of ovf_sticky, wins over a new set
module bicubic_dot_pipe #(
  parameter int TAPS   = 4,
  parameter int WW     = 3,
  parameter int PW     = 8,
  parameter int FRAC   = 3,
  parameter int OW     = 8,
  parameter int SAT_EN = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [TAPS*(WW+1)-1:0] weight_vec,
  input  logic [TAPS*(PW+1)-1:0] pixel_vec,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OW-1:0]          out_mag,
  output logic                   out_sign,
  output logic                   out_ovf,
  output logic                   ovf_sticky,
  input  logic                   clr_ovf
);

  // Per-tap product magnitude after dropping the weight fraction bits.
  localparam int PRODW = PW + WW - FRAC;
  // One extra bit per adder level plus the sign bit: the sum can never overflow.
  localparam int ACC   = PRODW + $clog2(TAPS) + 1;
  // |sum| zero-extended so overflow and wrap work for any OW vs ACC relation.
  localparam int XW    = ACC + OW;

  // Sign-magnitude tap product, truncated, returned as two's complement.
  // A zero magnitude is always +0 whatever the sign bits say.
  function automatic logic signed [ACC-1:0] tap_product(
    input logic [WW:0] w,
    input logic [PW:0] p
  );
    logic [WW+PW-1:0]       full;
    logic [PRODW-1:0]       mag;
    logic signed [ACC-1:0]  pos;
    full = {{PW{1'b0}}, w[WW-1:0]} * {{WW{1'b0}}, p[PW-1:0]};
    mag  = PRODW'(full >> FRAC);
    pos  = $signed({{(ACC-PRODW){1'b0}}, mag});
    if ((w[WW] ^ p[PW]) && (mag != '0)) return -pos;
    return pos;
  endfunction

  function automatic logic [ACC-1:0] abs_acc(input logic signed [ACC-1:0] v);
    logic signed [ACC-1:0] neg;
    neg = -v;
    return v[ACC-1] ? $unsigned(neg) : $unsigned(v);
  endfunction

  function automatic logic mag_overflow(input logic [ACC-1:0] a);
    logic [XW-1:0] ext;
    ext = {{OW{1'b0}}, a};
    return |(ext >> OW);
  endfunction

  function automatic logic [OW-1:0] sat_mag(input logic [ACC-1:0] a);
    logic [XW-1:0] ext;
    ext = {{OW{1'b0}}, a};
    if (mag_overflow(a) && (SAT_EN != 0)) return {OW{1'b1}};
    return ext[OW-1:0];
  endfunction

  logic                  advance;
  logic                  accept;
  logic                  vld_p0;
  logic                  vld_p1;
  logic signed [ACC-1:0] prod_p0 [TAPS];
  logic signed [ACC-1:0] sum_p1;
  logic signed [ACC-1:0] tree_sum;
  logic [ACC-1:0]        sum_abs;

  // Whole pipe moves together; a held output freezes every stage.
  assign in_ready = ~out_valid | out_ready;
  assign advance  = in_ready;
  assign accept   = in_valid & in_ready;

  // Stage 1: per-tap signed products, captured only on accept
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < TAPS; i++) begin
        prod_p0[i] <= tap_product(weight_vec[i*(WW+1) +: WW+1],
                                  pixel_vec[i*(PW+1) +: PW+1]);
      end
    end
  end

  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < TAPS; i++) begin
      tree_sum = tree_sum + prod_p0[i];
    end
  end

  // Stage 2: full-width signed sum
  always_ff @(posedge clk) begin
    if (advance && vld_p0) begin
      sum_p1 <= tree_sum;
    end
  end

  assign sum_abs = abs_acc(sum_p1);

  // Stage 3: sign/magnitude, saturation, sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      out_valid  <= 1'b0;
      out_mag    <= '0;
      out_sign   <= 1'b0;
      out_ovf    <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      if (advance) begin
        vld_p0    <= in_valid;
        vld_p1    <= vld_p0;
        out_valid <= vld_p1;
        if (vld_p1) begin
          out_mag  <= sat_mag(sum_abs);
          out_sign <= sum_p1[ACC-1];
          out_ovf  <= mag_overflow(sum_abs);
        end
      end
      if (clr_ovf) begin
        ovf_sticky <= 1'b0;
      end else if (out_valid && out_ready && out_ovf) begin
        ovf_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bicubic_dot_pipe.sv
// tb_bicubic_dot_pipe
//   Directed bench for bicubic_dot_pipe at default parameters, with a second
//   instance built with SAT_EN=0 sharing the same inputs for the wrap case.
module tb_bicubic_dot_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        clr_ovf = 1'b0;
  logic [15:0] weight_vec = '0;
  logic [35:0] pixel_vec = '0;

  logic        in_ready, out_valid, out_sign, out_ovf, ovf_sticky;
  logic [7:0]  out_mag;
  logic        w_in_ready, w_out_valid, w_out_sign, w_out_ovf, w_ovf_sticky;
  logic [7:0]  w_out_mag;

  int n_chk  = 0;
  int n_fail = 0;
  int rx_cnt = 0;
  logic mon_en = 1'b0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  bicubic_dot_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .weight_vec(weight_vec), .pixel_vec(pixel_vec), .out_valid(out_valid),
    .out_ready(out_ready), .out_mag(out_mag), .out_sign(out_sign),
    .out_ovf(out_ovf), .ovf_sticky(ovf_sticky), .clr_ovf(clr_ovf)
  );

  bicubic_dot_pipe #(.SAT_EN(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .weight_vec(weight_vec), .pixel_vec(pixel_vec), .out_valid(w_out_valid),
    .out_ready(out_ready), .out_mag(w_out_mag), .out_sign(w_out_sign),
    .out_ovf(w_out_ovf), .ovf_sticky(w_ovf_sticky), .clr_ovf(clr_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Result packed as {ovf, sign, mag} for the saturating instance.
  function automatic logic [9:0] ref_model(input logic [15:0] w, input logic [35:0] p);
    int s, wm, pm, m, a;
    logic ng;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      wm = int'(w[i*4 +: 3]);
      pm = int'(p[i*9 +: 8]);
      ng = w[i*4+3] ^ p[i*9+8];
      m  = (wm * pm) / 8;
      s  = ng ? s - m : s + m;
    end
    a = (s < 0) ? -s : s;
    return {(a > 255), (s < 0), (a > 255) ? 8'hFF : 8'(a)};
  endfunction

  // Accepted results are checked in order against the expected queue.
  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        chk("result", {out_ovf, out_sign, out_mag}, exp_q.pop_front());
      end
      rx_cnt++;
    end
  end

  // One vector through an empty pipe with out_ready high: exact 3-cycle latency.
  task automatic single(input string tag, input logic [15:0] w, input logic [35:0] p,
                        input logic [9:0] exp_res, input logic [7:0] exp_wrap,
                        input logic clr_on_acc);
    out_ready  = 1'b1;
    weight_vec = w;
    pixel_vec  = p;
    in_valid   = 1'b1;
    chk({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_lat1"}, out_valid, 0);
    @(posedge clk); #1;
    chk({tag, "_lat2"}, out_valid, 0);
    @(posedge clk); #1;
    chk({tag, "_lat3"}, out_valid, 1);
    chk({tag, "_res"}, {out_ovf, out_sign, out_mag}, exp_res);
    chk({tag, "_wrap_vld"}, w_out_valid, 1);
    chk({tag, "_wrap_mag"}, w_out_mag, exp_wrap);
    clr_ovf = clr_on_acc;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    chk({tag, "_drained"}, out_valid, 0);
  endtask

  initial begin
    logic [8:0]  pv;
    logic [63:0] r;
    logic [9:0]  snap;
    int base, g;

    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_mag", out_mag, 0);
    chk("rst_out_sign", out_sign, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_sticky", ovf_sticky, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors; first accept on the first edge after release
    single("pos128_w1",  16'h1111, {4{9'h080}}, 10'h040, 8'd64, 1'b0);
    single("pos128_wm1", 16'h9999, {4{9'h080}}, 10'h140, 8'd64, 1'b0);
    single("cancel",     16'h9191, {4{9'h080}}, 10'h000, 8'd0,  1'b0);
    single("mixed",      16'hD4B2, {9'h008, 9'h114, 9'h032, 9'h064}, 10'h108, 8'd8, 1'b0);
    single("trunc",      16'h3333, {4{9'h005}}, 10'h004, 8'd4,  1'b0);
    single("zero_prods", 16'hF799, {9'h000, 9'h100, 9'h007, 9'h105}, 10'h000, 8'd0, 1'b0);
    chk("sticky_quiet", ovf_sticky, 0);

    // Overflow, sticky set, clear, and clear winning over a same-cycle set
    single("ovf_pos", 16'h7777, {4{9'h0FF}}, 10'h2FF, 8'd124, 1'b0);
    chk("sticky_set", ovf_sticky, 1);
    chk("wrap_sticky_set", w_ovf_sticky, 1);
    chk("wrap_ovf_flag", w_out_ovf, 1);
    clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    chk("sticky_clr", ovf_sticky, 0);
    single("ovf_neg", 16'h7777, {4{9'h1FF}}, 10'h3FF, 8'd124, 1'b1);
    chk("sticky_clr_wins", ovf_sticky, 0);
    chk("wrap_sticky_clr_wins", w_ovf_sticky, 0);

    // Six back-to-back vectors with a 4-cycle output stall
    base   = rx_cnt;
    mon_en = 1'b1;
    for (int k = 1; k <= 6; k++) exp_q.push_back(10'(4 * k));
    fork
      begin
        for (int k = 1; k <= 6; k++) begin
          logic acc;
          int   gd;
          pv         = 9'(8 * k);
          weight_vec = 16'h1111;
          pixel_vec  = {4{pv}};
          in_valid   = 1'b1;
          acc = 1'b0;
          gd  = 0;
          while (!acc && gd < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            gd++;
          end
          if (!acc) chk("stall_drv_timeout", 0, 1);
        end
        in_valid = 1'b0;
      end
      begin
        int gs;
        gs = 0;
        while (!out_valid && gs < 20) begin
          @(posedge clk); #1;
          gs++;
        end
        chk("stall_first_valid", out_valid, 1);
        out_ready = 1'b0;
        snap = {out_ovf, out_sign, out_mag};
        repeat (4) begin
          @(posedge clk); #1;
          chk("stall_in_ready", in_ready, 0);
          chk("stall_valid_held", out_valid, 1);
          chk("stall_data_held", {out_ovf, out_sign, out_mag}, snap);
        end
        out_ready = 1'b1;
      end
    join
    g = 0;
    while ((rx_cnt - base) < 6 && g < 40) begin
      @(posedge clk); #1;
      g++;
    end
    chk("stall_count", rx_cnt - base, 6);
    chk("stall_queue_empty", exp_q.size(), 0);
    @(posedge clk); #1;
    chk("stall_no_dup", out_valid, 0);
    mon_en = 1'b0;

    // Reset with three vectors in flight
    out_ready  = 1'b1;
    weight_vec = 16'h1111; pixel_vec = {4{9'h080}}; in_valid = 1'b1;
    @(posedge clk); #1;
    weight_vec = 16'h9999;
    @(posedge clk); #1;
    weight_vec = 16'hD4B2; pixel_vec = {9'h008, 9'h114, 9'h032, 9'h064};
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("inflight_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_mag", out_mag, 0);
    chk("async_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    single("post_rst", 16'h7777, {4{9'h080}}, 10'h2FF, 8'd192, 1'b1);

    // Constrained random vectors with random bubbles and backpressure
    base   = rx_cnt;
    mon_en = 1'b1;
    for (int n = 0; n < 400; n++) begin
      r          = {$urandom, $urandom};
      weight_vec = 16'($urandom);
      pixel_vec  = r[35:0];
      if ($urandom_range(0, 7) == 0) pixel_vec = {4{9'h100}};
      if ($urandom_range(0, 7) == 0) weight_vec = 16'h8888;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) exp_q.push_back(ref_model(weight_vec, pixel_vec));
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    g = 0;
    while ((exp_q.size() != 0) && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    chk("rand_queue_empty", exp_q.size(), 0);
    chk("rand_some_results", (rx_cnt - base) > 50, 1);
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
